// File: rtl/sst_seq_engine.sv
// Save-state sequencer: the initiator on the mapper SST register bus.
// Save walks the identity byte and then regs 0..REG_CNT-1 out as a byte stream.
// Restore checks the identity byte and writes the remaining bytes back.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for save_req / rest_req
// S_SET  | save: load sst_addr (identity address first, then 0,1,..)
// S_CAP  | save: sst_addr settled, capture sst_di into out_data
// S_OUT  | save: out_valid held until the sink accepts the byte
// R_SET  | restore: point sst_addr at the identity address
// R_WAIT | restore: in_ready high, accept one byte
// R_WR   | restore: one-cycle sst_we_reg at the current sst_addr
// S_END  | release the bus, pulse done unless err
module sst_seq_engine #(
    parameter int REG_CNT  = 8,
    parameter int IDX_ADDR = 127
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       save_req,
    input  logic       rest_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    output logic       sst_we_reg,
    input  logic [7:0] sst_di,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);

    // The register index must fit below the identity address without wrapping.
    if (REG_CNT < 1 || REG_CNT > 126 || IDX_ADDR < REG_CNT || IDX_ADDR > 255) begin : g_bad_param
        $error("sst_seq_engine: REG_CNT must be 1..126 and IDX_ADDR in REG_CNT..255");
    end

    localparam logic [7:0] IDX_A    = 8'(IDX_ADDR);
    localparam logic [7:0] LAST_A   = 8'(REG_CNT - 1);
    localparam logic [7:0] LAST_CNT = 8'(REG_CNT);

    typedef enum logic [2:0] {
        IDLE, S_SET, S_CAP, S_OUT, R_SET, R_WAIT, R_WR, S_END
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;      // save: bytes already handed out (0 = identity byte next)
    logic       first_q;  // restore: next accepted byte is the identity byte

    // State register.
    always_ff @(posedge clk) begin
        if (map_rst) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        sst_act    = 1'b0;
        in_ready   = 1'b0;
        sst_we_reg = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (save_req)      state_nx = S_SET;
                else if (rest_req) state_nx = R_SET;
            end
            S_SET: begin
                busy = 1'b1; sst_act = 1'b1;
                state_nx = S_CAP;
            end
            S_CAP: begin
                busy = 1'b1; sst_act = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                busy = 1'b1; sst_act = 1'b1;
                if (out_valid && out_ready)
                    state_nx = (cnt == LAST_CNT) ? S_END : S_SET;
            end
            R_SET: begin
                busy = 1'b1; sst_act = 1'b1;
                state_nx = R_WAIT;
            end
            R_WAIT: begin
                busy = 1'b1; sst_act = 1'b1; in_ready = 1'b1;
                if (in_valid) begin
                    if (!first_q)              state_nx = R_WR;
                    else if (in_data != sst_di) state_nx = S_END;
                end
            end
            R_WR: begin
                busy = 1'b1; sst_act = 1'b1; sst_we_reg = 1'b1;
                state_nx = (sst_addr == LAST_A) ? S_END : R_WAIT;
            end
            S_END: begin
                done     = !err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: address walk, capture/stream registers and the sticky error.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            cnt       <= 8'd0;
            first_q   <= 1'b0;
            sst_addr  <= 8'd0;
            sst_dato  <= 8'd0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (save_req || rest_req) begin
                        err     <= 1'b0;
                        cnt     <= 8'd0;
                        first_q <= 1'b1;
                    end
                end
                S_SET: sst_addr <= (cnt == 8'd0) ? IDX_A : 8'(cnt - 8'd1);
                S_CAP: begin
                    out_data  <= sst_di;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= 8'(cnt + 8'd1);
                    end
                end
                R_SET: sst_addr <= IDX_A;
                R_WAIT: begin
                    if (in_valid) begin
                        if (first_q) begin
                            first_q <= 1'b0;
                            if (in_data != sst_di) err      <= 1'b1;
                            else                   sst_addr <= 8'd0;
                        end else begin
                            sst_dato <= in_data;
                        end
                    end
                end
                R_WR: begin
                    if (sst_addr != LAST_A) sst_addr <= 8'(sst_addr + 8'd1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sst_seq_engine.sv
// Directed bench for sst_seq_engine with a 3-register mapper model (identity 0x71).
module tb_sst_seq_engine;

    logic       clk = 1'b0;
    logic       map_rst, save_req, rest_req;
    logic       busy, done, err, sst_act, sst_we_reg;
    logic [7:0] sst_addr, sst_dato, sst_di, out_data, in_data;
    logic       out_valid, out_ready, in_valid, in_ready;

    always #5 clk = ~clk;

    sst_seq_engine #(.REG_CNT(3), .IDX_ADDR(127)) dut (
        .clk(clk), .map_rst(map_rst), .save_req(save_req), .rest_req(rest_req),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act),
        .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_we_reg(sst_we_reg), .sst_di(sst_di),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    // Mapper responder model.
    logic [7:0] regs  [0:2];
    logic [7:0] pre_r [0:2];
    logic       preload = 1'b0;

    always_comb begin
        sst_di = 8'h00;
        if (sst_addr == 8'd127)    sst_di = 8'h71;
        else if (sst_addr < 8'd3)  sst_di = regs[sst_addr[1:0]];
    end

    always @(posedge clk) begin
        if (preload) begin
            regs[0] <= pre_r[0]; regs[1] <= pre_r[1]; regs[2] <= pre_r[2];
        end else if (sst_we_reg && sst_addr < 8'd3) begin
            regs[sst_addr[1:0]] <= sst_dato;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-operation observations.
    logic [7:0] stream [0:3];
    logic [7:0] got_b  [0:7];
    logic [7:0] wr_a   [0:7];
    logic [7:0] wr_d   [0:7];
    int n_got, we_cnt, done_cnt, k, rdy_seen;

    task automatic set_stream(input logic [7:0] a, b, c, d);
        stream[0] = a; stream[1] = b; stream[2] = c; stream[3] = d;
    endtask

    task automatic preload_regs(input logic [7:0] a, b, c);
        pre_r[0] = a; pre_r[1] = b; pre_r[2] = c;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
    endtask

    // Runs one operation for a fixed 60-cycle window, driving and sampling at negedge.
    // rmode 0: out_ready always high; 1: high one cycle in three.
    task automatic run_op(input logic sv, input logic rs, input int rmode,
                          input logic rst_on_wr, input int mid_rs);
        logic       prev_hold, rst_pending, rst_armed;
        logic [7:0] prev_data;
        n_got = 0; we_cnt = 0; done_cnt = 0; k = 0; rdy_seen = 0;
        prev_hold = 1'b0; rst_pending = 1'b0; rst_armed = rst_on_wr; prev_data = 8'h00;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_start", busy, 1);
                chk("act_start", sst_act, 1);
                chk("err_clr", err, 0);
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (sst_we_reg) begin
                if (we_cnt < 8) begin wr_a[we_cnt] = sst_addr; wr_d[we_cnt] = sst_dato; end
                we_cnt++;
            end
            if (done) done_cnt++;
            if (in_ready) rdy_seen++;
            if (rst_pending) begin
                map_rst = 1'b0;
                rst_pending = 1'b0;
                chk("rst_outs", {busy, done, err, sst_act, sst_we_reg, out_valid, in_ready,
                                 sst_addr, sst_dato, out_data}, 0);
            end else if (rst_armed && sst_we_reg) begin
                map_rst = 1'b1;
                rst_pending = 1'b1;
                rst_armed = 1'b0;
            end
            save_req  = (cyc == 0) && sv;
            rest_req  = ((cyc == 0) && rs) || (cyc == mid_rs);
            out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 2);
            in_valid  = (k < 4);
            in_data   = (k < 4) ? stream[k] : 8'h00;
            if (out_valid && out_ready && !map_rst) begin
                if (n_got < 8) got_b[n_got] = out_data;
                n_got++;
            end
            if (in_valid && in_ready && !map_rst) k++;
            prev_hold = out_valid && !out_ready && !map_rst;
            prev_data = out_data;
        end
        save_req = 1'b0; rest_req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic check_save(input string tag, input logic [7:0] a, b, c, d);
        chk({tag, "_nbytes"}, n_got, 4);
        chk({tag, "_b0"}, got_b[0], a);
        chk({tag, "_b1"}, got_b[1], b);
        chk({tag, "_b2"}, got_b[2], c);
        chk({tag, "_b3"}, got_b[3], d);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_we"}, we_cnt, 0);
    endtask

    initial begin
        map_rst = 1'b1; save_req = 1'b0; rest_req = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        set_stream(8'h00, 8'h00, 8'h00, 8'h00);
        preload_regs(8'h05, 8'h0A, 8'h01);
        repeat (2) @(negedge clk);
        chk("reset_outs", {busy, done, err, sst_act, sst_we_reg, out_valid, in_ready,
                           sst_addr, sst_dato, out_data}, 0);
        map_rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", {busy, done, sst_act, in_ready, out_valid}, 0);

        // 1: save, sink always ready
        run_op(1'b1, 1'b0, 0, 1'b0, -1);
        check_save("save1", 8'h71, 8'h05, 8'h0A, 8'h01);

        // 2: save with sink ready one cycle in three
        run_op(1'b1, 1'b0, 1, 1'b0, -1);
        check_save("save2", 8'h71, 8'h05, 8'h0A, 8'h01);

        // 3: restore 71,03,07,00
        set_stream(8'h71, 8'h03, 8'h07, 8'h00);
        run_op(1'b0, 1'b1, 0, 1'b0, -1);
        chk("rest_we", we_cnt, 3);
        chk("rest_done", done_cnt, 1);
        chk("rest_wa0", wr_a[0], 0); chk("rest_wd0", wr_d[0], 8'h03);
        chk("rest_wa1", wr_a[1], 1); chk("rest_wd1", wr_d[1], 8'h07);
        chk("rest_wa2", wr_a[2], 2); chk("rest_wd2", wr_d[2], 8'h00);
        chk("rest_reg0", regs[0], 8'h03);
        chk("rest_reg1", regs[1], 8'h07);
        chk("rest_reg2", regs[2], 8'h00);
        chk("rest_act_end", sst_act, 0);
        run_op(1'b1, 1'b0, 0, 1'b0, -1);
        check_save("readback", 8'h71, 8'h03, 8'h07, 8'h00);

        // 4: identity mismatch
        set_stream(8'h4F, 8'h11, 8'h22, 8'h33);
        run_op(1'b0, 1'b1, 0, 1'b0, -1);
        chk("mis_err", err, 1);
        chk("mis_we", we_cnt, 0);
        chk("mis_done", done_cnt, 0);
        chk("mis_accepted", k, 1);
        chk("mis_busy_end", busy, 0);
        run_op(1'b1, 1'b0, 0, 1'b0, -1);
        check_save("after_err", 8'h71, 8'h03, 8'h07, 8'h00);
        chk("after_err_err", err, 0);

        // 5: reset during restore, right as the first write strobe is out
        set_stream(8'h71, 8'h0C, 8'h0D, 8'h0E);
        run_op(1'b0, 1'b1, 0, 1'b1, -1);
        chk("rst_we", we_cnt, 1);
        chk("rst_done", done_cnt, 0);
        chk("rst_reg0", regs[0], 8'h0C);
        chk("rst_reg1", regs[1], 8'h07);
        run_op(1'b0, 1'b1, 0, 1'b0, -1);
        chk("rerest_we", we_cnt, 3);
        chk("rerest_done", done_cnt, 1);
        chk("rerest_reg1", regs[1], 8'h0D);
        chk("rerest_reg2", regs[2], 8'h0E);

        // 6: simultaneous requests, save wins; mid-save rest_req ignored
        set_stream(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        run_op(1'b1, 1'b1, 0, 1'b0, 8);
        check_save("both", 8'h71, 8'h0C, 8'h0D, 8'h0E);
        chk("both_in_ready", rdy_seen, 0);
        chk("both_accepted", k, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
